matmul_stream_controller: RTL and testbench



---
 rtl/matmul_stream_controller_if.sv | 11 +
 rtl/matmul_stream_controller.sv | 157 +++++++++++++++
 tb/tb_matmul_stream_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_stream_controller_if.sv
// One AXI Stream channel (data, valid, ready, last). The controller uses
// one instance as its operand input and another as its result output.
interface matmul_stream_controller_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/matmul_stream_controller.sv
// Stream-side controller for the matrix-multiply coprocessor.
// Operand words arriving on s_axis are written into A_RAM and then B_RAM.
// The multiply core is started with a one-cycle Start pulse. After Done,
// RES_RAM is read one word at a time and each word is sent on m_axis.
// TLAST is set on the final result word.
module matmul_stream_controller #(
    parameter int width          = 8,
    parameter int A_depth_bits   = 3,
    parameter int B_depth_bits   = 2,
    parameter int RES_depth_bits = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    matmul_stream_controller_if.slave  s_axis,
    matmul_stream_controller_if.master m_axis,
    output logic                      A_write_en,
    output logic [A_depth_bits-1:0]   A_write_address,
    output logic [width-1:0]          A_write_data_in,
    output logic                      B_write_en,
    output logic [B_depth_bits-1:0]   B_write_address,
    output logic [width-1:0]          B_write_data_in,
    output logic                      Start,
    input  logic                      Done,
    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data_out
);

    localparam int A_ELEMS   = 1 << A_depth_bits;
    localparam int B_ELEMS   = 1 << B_depth_bits;
    localparam int RES_ELEMS = 1 << RES_depth_bits;
    localparam int IN_WORDS  = A_ELEMS + B_ELEMS;
    localparam int IN_W      = $clog2(IN_WORDS);
    localparam int J_W       = (RES_ELEMS > 1) ? $clog2(RES_ELEMS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_INPUTS,
        FLUSH,
        COMPUTE,
        READ_RES,
        WAIT_RES,
        SEND
    } state_t;

    state_t state_q, state_d;

    logic [IN_W-1:0] in_cnt;
    logic [J_W-1:0]  res_idx;
    logic            in_hs;
    logic            in_last;
    logic            res_last;
    logic [31:0]     m_tdata_q;
    logic            m_tvalid_q;
    logic            m_tlast_q;
    logic            unused_in;

    // TLAST and the upper data bits are not needed: the frame length is
    // taken from the word count.
    assign unused_in = ^{s_axis.tlast, s_axis.tdata[31:width]};

    assign in_hs    = (state_q == READ_INPUTS) && s_axis.tvalid;
    assign in_last  = (in_cnt == IN_W'(IN_WORDS - 1));
    assign res_last = (res_idx == J_W'(RES_ELEMS - 1));

    assign s_axis.tready    = (state_q == READ_INPUTS);
    assign RES_read_en      = (state_q == READ_RES);
    assign RES_read_address = RES_depth_bits'(res_idx);
    assign m_axis.tdata     = m_tdata_q;
    assign m_axis.tvalid    = m_tvalid_q;
    assign m_axis.tlast     = m_tlast_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = READ_INPUTS;
            READ_INPUTS: if (in_hs && in_last) state_d = FLUSH;
            FLUSH:       state_d = COMPUTE;
            COMPUTE:     if (Done) state_d = READ_RES;
            READ_RES:    state_d = WAIT_RES;
            WAIT_RES:    state_d = SEND;
            SEND:        if (m_axis.tready) state_d = res_last ? IDLE : READ_RES;
            default:     state_d = IDLE;
        endcase
    end

    // Input word counter and result index; both cleared in Idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt  <= '0;
            res_idx <= '0;
        end else if (state_q == IDLE) begin
            in_cnt  <= '0;
            res_idx <= '0;
        end else begin
            if (in_hs) in_cnt <= in_last ? '0 : in_cnt + IN_W'(1);
            if (state_q == SEND && m_axis.tready && !res_last)
                res_idx <= res_idx + J_W'(1);
        end
    end

    // Registered RAM writes: the enable is high in the cycle after the handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A_write_en      <= 1'b0;
            A_write_address <= '0;
            A_write_data_in <= '0;
            B_write_en      <= 1'b0;
            B_write_address <= '0;
            B_write_data_in <= '0;
        end else begin
            A_write_en <= 1'b0;
            B_write_en <= 1'b0;
            if (in_hs) begin
                if (in_cnt < IN_W'(A_ELEMS)) begin
                    A_write_en      <= 1'b1;
                    A_write_address <= A_depth_bits'(in_cnt);
                    A_write_data_in <= s_axis.tdata[width-1:0];
                end else begin
                    B_write_en      <= 1'b1;
                    B_write_address <= B_depth_bits'(in_cnt - IN_W'(A_ELEMS));
                    B_write_data_in <= s_axis.tdata[width-1:0];
                end
            end
        end
    end

    // Start pulse in the first Compute cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) Start <= 1'b0;
        else       Start <= (state_q == FLUSH);
    end

    // Result output register: loaded in Wait_Res, held through Send
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else if (state_q == WAIT_RES) begin
            m_tdata_q  <= 32'(RES_read_data_out);
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= res_last;
        end else if (state_q == SEND && m_axis.tready) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matmul_stream_controller.sv
// Directed bench for matmul_stream_controller with behavioural RAMs and core.
module tb_matmul_stream_controller;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    matmul_stream_controller_if s_if ();
    matmul_stream_controller_if m_if ();

    logic       A_write_en, B_write_en, Start, Done, RES_read_en;
    logic [2:0] A_write_address;
    logic [1:0] B_write_address;
    logic [0:0] RES_read_address;
    logic [7:0] A_write_data_in, B_write_data_in, RES_read_data_out;

    logic [7:0] a_mem [8];
    logic [7:0] b_mem [4];
    logic [7:0] res_mem [2];
    logic [7:0] fa [12];

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   start_cnt = 0;
    int   stall_n = 0;
    bit   done_same = 0;

    matmul_stream_controller #(
        .width(8), .A_depth_bits(3), .B_depth_bits(2), .RES_depth_bits(1)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis(s_if), .m_axis(m_if),
        .A_write_en(A_write_en), .A_write_address(A_write_address),
        .A_write_data_in(A_write_data_in),
        .B_write_en(B_write_en), .B_write_address(B_write_address),
        .B_write_data_in(B_write_data_in),
        .Start(Start), .Done(Done),
        .RES_read_en(RES_read_en), .RES_read_address(RES_read_address),
        .RES_read_data_out(RES_read_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_res(input int r);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s += 32'(fa[r*4+k]) * 32'(fa[8+k]);
        return s[15:8];
    endfunction

    // Behavioural A/B RAM writes and synchronous RES_RAM read
    always @(posedge clk) begin
        if (A_write_en) a_mem[A_write_address] <= A_write_data_in;
        if (B_write_en) b_mem[B_write_address] <= B_write_data_in;
        if (RES_read_en) RES_read_data_out <= res_mem[RES_read_address];
    end

    // Core model, input/output protocol monitor and output scoreboard
    bit          hs_prev, start_prev, busy, hold_valid;
    logic [31:0] hold_data;
    logic        hold_last;
    int          rx_words, cd, stall_cnt;
    always @(negedge clk) begin
        if (reset) begin
            hs_prev = 0; start_prev = 0; busy = 0; hold_valid = 0;
            rx_words = 0; cd = 0; stall_cnt = 0;
            Done = 0; m_if.tready = 0;
        end else begin
            chk("wr_en_timing", 32'(A_write_en | B_write_en), 32'(hs_prev));
            if (busy) chk("s_tready_busy", 32'(s_if.tready), 0);
            hs_prev = s_if.tvalid && s_if.tready;
            if (hs_prev) begin
                rx_words++;
                if (rx_words == 12) begin rx_words = 0; busy = 1; end
            end

            if (Start) begin
                start_cnt++;
                chk("start_one_cycle", 32'(start_prev), 0);
            end
            start_prev = Start;
            Done = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) Done = 1;
            end
            if (Start) begin
                for (int r = 0; r < 2; r++) begin
                    logic [31:0] s;
                    s = '0;
                    for (int k = 0; k < 4; k++) s += 32'(a_mem[r*4+k]) * 32'(b_mem[k]);
                    res_mem[r] = s[15:8];
                end
                if (done_same) Done = 1;
                else cd = 10;
            end

            if (hold_valid) begin
                chk("m_tvalid_stable", 32'(m_if.tvalid), 1);
                chk("m_tdata_stable", m_if.tdata, hold_data);
                chk("m_tlast_stable", 32'(m_if.tlast), 32'(hold_last));
            end
            if (m_if.tvalid && stall_cnt < stall_n) begin
                m_if.tready = 0;
                stall_cnt++;
            end else begin
                m_if.tready = m_if.tvalid ? 1'b1 : (stall_n == 0);
            end
            if (m_if.tvalid && m_if.tready) begin
                stall_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", m_if.tdata, 32'hxxxxxxxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("m_tdata", m_if.tdata, e.data);
                    chk("m_tlast", 32'(m_if.tlast), 32'(e.last));
                    if (e.last) busy = 0;
                end
            end
            hold_valid = m_if.tvalid && !m_if.tready;
            hold_data  = m_if.tdata;
            hold_last  = m_if.tlast;
        end
    end

    task automatic send_word(input logic [7:0] d, input bit last, input bit gap);
        bit ok;
        ok = 0;
        s_if.tdata  = {$urandom_range(0, 32'hFFFFFF), d};
        s_if.tlast  = last;
        s_if.tvalid = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (s_if.tready === 1'b1) begin ok = 1; break; end
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 0;
        s_if.tlast  = 0;
        chk("s_handshake_timeout", 32'(ok), 1);
        if (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input bit gap);
        for (int r = 0; r < 2; r++) exp_q.push_back('{data: {24'h0, ref_res(r)}, last: (r == 1)});
        for (int i = 0; i < 12; i++) send_word(fa[i], i == 11, gap);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 600) begin @(negedge clk); c++; end
        chk("drain_timeout", 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_rams();
        for (int i = 0; i < 8; i++) chk("a_ram", 32'(a_mem[i]), 32'(fa[i]));
        for (int i = 0; i < 4; i++) chk("b_ram", 32'(b_mem[i]), 32'(fa[8+i]));
    endtask

    task automatic check_reset_vals();
        chk("rst_ctrl", 32'({s_if.tready, m_if.tvalid, m_if.tlast, Start, A_write_en,
                             B_write_en, RES_read_en, A_write_address, B_write_address,
                             RES_read_address}), 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_wdata", 32'({A_write_data_in, B_write_data_in}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0;
        Done = 0; m_if.tready = 0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 0;
        #1;
        chk("idle_tready", 32'(s_if.tready), 0);
        @(negedge clk);
        chk("read_tready", 32'(s_if.tready), 1);
        @(posedge clk); #1;

        // Scenario 1: uniform 0x10, back-to-back
        for (int i = 0; i < 12; i++) fa[i] = 8'h10;
        send_frame(0);
        wait_drain();
        check_rams();
        chk("start_cnt_s1", start_cnt, 1);

        // Scenario 2: ramp with gaps between words
        for (int i = 0; i < 8; i++) fa[i] = 8'(i + 1);
        for (int i = 8; i < 12; i++) fa[i] = 8'h01;
        @(posedge clk); #1;
        send_frame(1);
        wait_drain();
        check_rams();
        chk("start_cnt_s2", start_cnt, 2);

        // Scenario 3: all 0xFF, output stalled 5 cycles per word
        for (int i = 0; i < 12; i++) fa[i] = 8'hFF;
        stall_n = 5;
        @(posedge clk); #1;
        send_frame(0);
        wait_drain();
        stall_n = 0;
        check_rams();
        chk("start_cnt_s3", start_cnt, 3);

        // Scenario 4: reset after 5 words, then a full frame
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send_word(8'h5A + 8'(i), 0, 0);
        @(negedge clk);
        #3 reset = 1;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) fa[i] = 8'h40 + 8'(i * 16);
        for (int i = 0; i < 4; i++) fa[8+i] = 8'(8 * (i + 1));
        send_frame(0);
        wait_drain();
        check_rams();
        chk("start_cnt_s4", start_cnt, 4);

        // Scenario 5: two frames back-to-back
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) fa[i] = 8'(i * 17);
        fa[8] = 8'h80; fa[9] = 8'h40; fa[10] = 8'h20; fa[11] = 8'h10;
        send_frame(0);
        for (int i = 0; i < 12; i++) fa[i] = 8'($urandom_range(0, 255));
        send_frame(0);
        wait_drain();
        check_rams();
        chk("start_cnt_s5", start_cnt, 6);

        // Scenario 6: Done in the same cycle as Start
        done_same = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) fa[i] = 8'hF0 - 8'(i * 7);
        send_frame(0);
        wait_drain();
        check_rams();
        chk("start_cnt_s6", start_cnt, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
